// File: rtl/riscv_dual_imem_responder_pkg.sv
// VC memory message layout shared by the dual instruction-memory responder and its users.
package riscv_dual_imem_responder_pkg;

    localparam int unsigned VC_MEM_REQ_MSG_TYPE_SZ  = 1;
    localparam int unsigned VC_MEM_REQ_MSG_ADDR_SZ  = 32;
    localparam int unsigned VC_MEM_REQ_MSG_LEN_SZ   = 2;
    localparam int unsigned VC_MEM_REQ_MSG_DATA_SZ  = 32;
    localparam int unsigned VC_MEM_REQ_MSG_SZ       = VC_MEM_REQ_MSG_TYPE_SZ + VC_MEM_REQ_MSG_ADDR_SZ
                                                    + VC_MEM_REQ_MSG_LEN_SZ + VC_MEM_REQ_MSG_DATA_SZ;
    localparam int unsigned VC_MEM_RESP_MSG_TYPE_SZ = 1;
    localparam int unsigned VC_MEM_RESP_MSG_LEN_SZ  = 2;
    localparam int unsigned VC_MEM_RESP_MSG_DATA_SZ = 32;
    localparam int unsigned VC_MEM_RESP_MSG_SZ      = VC_MEM_RESP_MSG_TYPE_SZ + VC_MEM_RESP_MSG_LEN_SZ
                                                    + VC_MEM_RESP_MSG_DATA_SZ;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    // {type[66], addr[65:34], len[33:32], data[31:0]}
    typedef struct packed {
        mem_type_e                          mtype;
        logic [VC_MEM_REQ_MSG_ADDR_SZ-1:0]  addr;
        logic [VC_MEM_REQ_MSG_LEN_SZ-1:0]   len;
        logic [VC_MEM_REQ_MSG_DATA_SZ-1:0]  data;
    } mem_req_msg_t;

    // {type[34], len[33:32], data[31:0]}
    typedef struct packed {
        mem_type_e                          mtype;
        logic [VC_MEM_RESP_MSG_LEN_SZ-1:0]  len;
        logic [VC_MEM_RESP_MSG_DATA_SZ-1:0] data;
    } mem_resp_msg_t;

    // Writes answer with zero data; reads return the full word whatever len says.
    function automatic mem_resp_msg_t mk_resp(input mem_type_e                         mtype,
                                              input logic [VC_MEM_REQ_MSG_LEN_SZ-1:0]   len,
                                              input logic [VC_MEM_RESP_MSG_DATA_SZ-1:0] rdata);
        mem_resp_msg_t r;
        r.mtype = mtype;
        r.len   = len;
        r.data  = (mtype == MEM_WRITE) ? '0 : rdata;
        return r;
    endfunction

endpackage

// File: rtl/riscv_dual_imem_responder_if.sv
// Two-port fetch request/response bundle: the core is master, the memory responder is slave.
interface riscv_dual_imem_responder_if;

    logic                                          memreq0_val;
    logic                                          memreq0_rdy;
    riscv_dual_imem_responder_pkg::mem_req_msg_t   memreq0_msg;
    logic                                          memresp0_val;
    logic                                          memresp0_rdy;
    riscv_dual_imem_responder_pkg::mem_resp_msg_t  memresp0_msg;

    logic                                          memreq1_val;
    logic                                          memreq1_rdy;
    riscv_dual_imem_responder_pkg::mem_req_msg_t   memreq1_msg;
    logic                                          memresp1_val;
    logic                                          memresp1_rdy;
    riscv_dual_imem_responder_pkg::mem_resp_msg_t  memresp1_msg;

    modport master (
        output memreq0_val, memreq0_msg, memresp0_rdy,
        output memreq1_val, memreq1_msg, memresp1_rdy,
        input  memreq0_rdy, memresp0_val, memresp0_msg,
        input  memreq1_rdy, memresp1_val, memresp1_msg
    );

    modport slave (
        input  memreq0_val, memreq0_msg, memresp0_rdy,
        input  memreq1_val, memreq1_msg, memresp1_rdy,
        output memreq0_rdy, memresp0_val, memresp0_msg,
        output memreq1_rdy, memresp1_val, memresp1_msg
    );

endinterface

// File: rtl/riscv_ImemRespPort.sv
// One response path: fixed-latency delay line into an in-order FIFO, gated by a credit counter
// so the FIFO can never overflow and the delay line never has to stall.
module riscv_ImemRespPort
    import riscv_dual_imem_responder_pkg::*;
#(
    parameter int unsigned p_latency = 2,
    parameter int unsigned p_q_depth = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acc_i,
    input  mem_resp_msg_t msg_i,
    output logic          rdy_o,
    output logic          resp_val_o,
    input  logic          resp_rdy_i,
    output mem_resp_msg_t resp_msg_o
);

    localparam int unsigned     CntW    = $clog2(p_q_depth + 1);
    localparam int unsigned     PtrW    = (p_q_depth > 1) ? $clog2(p_q_depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(p_q_depth - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(p_q_depth);

    logic          dl_val;
    mem_resp_msg_t dl_msg;

    // The accept edge is the first stage, so p_latency-1 registers follow it.
    if (p_latency <= 1) begin : g_dl_none
        assign dl_val = acc_i;
        assign dl_msg = msg_i;
    end else begin : g_dl_pipe
        localparam int unsigned Stages = p_latency - 1;
        logic [Stages-1:0] val_q;
        mem_resp_msg_t     msg_q [Stages];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                val_q <= '0;
            end else begin
                val_q[0] <= acc_i;
                for (int unsigned i = 1; i < Stages; i++) val_q[i] <= val_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            msg_q[0] <= msg_i;
            for (int unsigned i = 1; i < Stages; i++) msg_q[i] <= msg_q[i-1];
        end

        assign dl_val = val_q[Stages-1];
        assign dl_msg = msg_q[Stages-1];
    end

    mem_resp_msg_t   fifo_q [p_q_depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d, occ_q, occ_d;
    logic            resp_val_q, resp_val_d;
    logic            fire;

    assign fire = resp_val_q && resp_rdy_i;

    // cnt covers in-flight plus queued responses; occ is just the FIFO occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        occ_d      = occ_q;
        if (dl_val) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        if (fire)   rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        case ({acc_i, fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({dl_val, fire})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        resp_val_d = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            occ_q      <= '0;
            resp_val_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            resp_val_q <= resp_val_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dl_val) fifo_q[wr_ptr_q] <= dl_msg;
    end

    assign rdy_o      = reset && (cnt_q < CntMax);
    assign resp_val_o = resp_val_q;
    assign resp_msg_o = fifo_q[rd_ptr_q];

endmodule

// File: rtl/riscv_dual_imem_responder.sv
// Dual-port instruction-memory responder: one shared word array m (loaded by the simulator)
// serving two independent fixed-latency response paths.
module riscv_dual_imem_responder
    import riscv_dual_imem_responder_pkg::*;
#(
    parameter int unsigned p_mem_sz  = 1 << 20,
    parameter int unsigned p_addr_sz = 32,
    parameter int unsigned p_data_sz = 32,
    parameter int unsigned p_latency = 2,
    parameter int unsigned p_q_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    riscv_dual_imem_responder_if.slave   bus
);

    localparam int unsigned Words = p_mem_sz / 4;
    localparam int unsigned IdxW  = $clog2(Words);

    logic [p_data_sz-1:0] m [Words];

    mem_req_msg_t         req0, req1;
    logic [p_addr_sz-1:0] addr0, addr1;
    logic [IdxW-1:0]      idx0, idx1;
    logic                 rdy0, rdy1, acc0, acc1;
    mem_resp_msg_t        resp_in0, resp_in1;
    logic                 unused_addr_bits;

    assign req0  = bus.memreq0_msg;
    assign req1  = bus.memreq1_msg;
    assign addr0 = p_addr_sz'(req0.addr);
    assign addr1 = p_addr_sz'(req1.addr);
    assign idx0  = addr0[IdxW+1:2];
    assign idx1  = addr1[IdxW+1:2];
    assign unused_addr_bits = ^{addr0[p_addr_sz-1:IdxW+2], addr0[1:0],
                                addr1[p_addr_sz-1:IdxW+2], addr1[1:0]};

    assign acc0 = bus.memreq0_val && rdy0;
    assign acc1 = bus.memreq1_val && rdy1;
    assign bus.memreq0_rdy = rdy0;
    assign bus.memreq1_rdy = rdy1;

    // Reads sample the array before this edge's writes land, so read-vs-write returns old data.
    assign resp_in0 = mk_resp(req0.mtype, req0.len, 32'(m[idx0]));
    assign resp_in1 = mk_resp(req1.mtype, req1.len, 32'(m[idx1]));

    // Port 1 is written last so it wins a same-index dual write; no reset on the array.
    always_ff @(posedge clk) begin
        if (acc0 && (req0.mtype == MEM_WRITE)) m[idx0] <= p_data_sz'(req0.data);
        if (acc1 && (req1.mtype == MEM_WRITE)) m[idx1] <= p_data_sz'(req1.data);
    end

    riscv_ImemRespPort #(
        .p_latency (p_latency),
        .p_q_depth (p_q_depth)
    ) u_port0 (
        .clk        (clk),
        .reset      (reset),
        .acc_i      (acc0),
        .msg_i      (resp_in0),
        .rdy_o      (rdy0),
        .resp_val_o (bus.memresp0_val),
        .resp_rdy_i (bus.memresp0_rdy),
        .resp_msg_o (bus.memresp0_msg)
    );

    riscv_ImemRespPort #(
        .p_latency (p_latency),
        .p_q_depth (p_q_depth)
    ) u_port1 (
        .clk        (clk),
        .reset      (reset),
        .acc_i      (acc1),
        .msg_i      (resp_in1),
        .rdy_o      (rdy1),
        .resp_val_o (bus.memresp1_val),
        .resp_rdy_i (bus.memresp1_rdy),
        .resp_msg_o (bus.memresp1_msg)
    );

endmodule

// File: tb/tb_riscv_dual_imem_responder.sv
// Randomized scoreboard bench: a word-map reference model predicts each response and its due cycle.
module tb_riscv_dual_imem_responder;
    import riscv_dual_imem_responder_pkg::*;

    localparam int Lat    = 2;
    localparam int QDepth = 4;
    localparam int MemSz  = 1 << 20;
    localparam int Words  = MemSz / 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    riscv_dual_imem_responder_if bus ();

    riscv_dual_imem_responder #(
        .p_mem_sz  (MemSz),
        .p_addr_sz (32),
        .p_data_sz (32),
        .p_latency (Lat),
        .p_q_depth (QDepth)
    ) mem (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [34:0] msg;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [int];
    int          edge_n      = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'(Words - 1));
    endfunction

    function automatic logic [34:0] model_resp(input mem_req_msg_t r);
        if (r.mtype == MEM_WRITE) return {1'b1, r.len, 32'h0};
        return {1'b0, r.len, ref_mem[widx(r.addr)]};
    endfunction

    function automatic mem_req_msg_t rq(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        mem_req_msg_t r;
        r.mtype = wr ? MEM_WRITE : MEM_READ;
        r.addr  = addr;
        r.len   = 2'($urandom);
        r.data  = data;
        return r;
    endfunction

    // Monitor: a due head must be presented (and held while stalled); nothing may appear early.
    task automatic mon_port(input int p, input logic val, input logic rr, input logic [34:0] msg);
        exp_t head;
        bit   is_due = 1'b0;
        if (p == 0 && q0.size() > 0) begin head = q0[0]; is_due = (head.due <= edge_n); end
        if (p == 1 && q1.size() > 0) begin head = q1[0]; is_due = (head.due <= edge_n); end
        if (is_due) begin
            check($sformatf("resp%0d_msg", p), {28'h0, val, msg}, {28'h0, 1'b1, head.msg});
            if (val && rr) begin
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else begin
            check($sformatf("resp%0d_idle", p), 64'(val), 64'h0);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, bus.memresp0_val, bus.memresp0_rdy, bus.memresp0_msg);
        mon_port(1, bus.memresp1_val, bus.memresp1_rdy, bus.memresp1_msg);
    end

    // One cycle of stimulus, driven just after the edge; accepts take effect at the next edge.
    task automatic step(input bit v0, input mem_req_msg_t r0, input bit rr0,
                        input bit v1, input mem_req_msg_t r1, input bit rr1,
                        output bit a0, output bit a1);
        exp_t e;
        @(posedge clk);
        #1;
        check("req0_rdy", 64'(bus.memreq0_rdy), 64'(reset && (q0.size() < QDepth)));
        check("req1_rdy", 64'(bus.memreq1_rdy), 64'(reset && (q1.size() < QDepth)));
        bus.memreq0_val  = v0;
        bus.memreq0_msg  = r0;
        bus.memresp0_rdy = rr0;
        bus.memreq1_val  = v1;
        bus.memreq1_msg  = r1;
        bus.memresp1_rdy = rr1;
        a0 = v0 && bus.memreq0_rdy;
        a1 = v1 && bus.memreq1_rdy;
        e.due = edge_n + Lat;
        if (a0) begin e.msg = model_resp(r0); q0.push_back(e); end
        if (a1) begin e.msg = model_resp(r1); q1.push_back(e); end
        if (a0 && r0.mtype == MEM_WRITE) ref_mem[widx(r0.addr)] = r0.data;
        if (a1 && r1.mtype == MEM_WRITE) ref_mem[widx(r1.addr)] = r1.data;
    endtask

    task automatic idle(input int n, input bit rr0);
        bit a0, a1;
        for (int i = 0; i < n; i++) step(1'b0, '0, rr0, 1'b0, '0, 1'b1, a0, a1);
    endtask

    initial begin
        bit a0, a1;
        int n0, n1, k;
        logic [31:0] a;

        bus.memreq0_val  = 1'b0;
        bus.memreq0_msg  = '0;
        bus.memresp0_rdy = 1'b0;
        bus.memreq1_val  = 1'b0;
        bus.memreq1_msg  = '0;
        bus.memresp1_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req0_rdy", 64'(bus.memreq0_rdy), 64'h0);
        check("rst_req1_rdy", 64'(bus.memreq1_rdy), 64'h0);
        check("rst_resp0_val", 64'(bus.memresp0_val), 64'h0);
        check("rst_resp1_val", 64'(bus.memresp1_val), 64'h0);
        @(negedge clk) reset = 1'b1;

        // Preload through the ports
        for (int i = 0; i < 8; i++)
            step(1'b1, rq(1'b1, 32'h100 + 32'(4 * i), (i == 0) ? 32'h0050_0093 : $urandom), 1'b1,
                 1'b1, rq(1'b1, 32'h200 + 32'(4 * i), $urandom), 1'b1, a0, a1);
        step(1'b1, rq(1'b1, 32'h300, 32'h1111_1111), 1'b1, 1'b0, '0, 1'b1, a0, a1);
        idle(4, 1'b1);

        // Single read, latency checked by the monitor
        step(1'b1, rq(1'b0, 32'h100, $urandom), 1'b1, 1'b0, '0, 1'b1, a0, a1);
        idle(4, 1'b1);

        // Back-to-back on both ports
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rq(1'b0, 32'h100 + 32'(4 * i), $urandom), 1'b1,
                 1'b1, rq(1'b0, 32'h200 + 32'(4 * i), $urandom), 1'b1, a0, a1);
            check("b2b_acc0", 64'(a0), 64'h1);
            check("b2b_acc1", 64'(a1), 64'h1);
        end
        idle(4, 1'b1);

        // Port 0 backpressured; port 1 must keep going
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rq(1'b0, 32'h100 + 32'(4 * i), $urandom), 1'b0,
                 1'b1, rq(1'b0, 32'h200 + 32'(4 * i), $urandom), 1'b1, a0, a1);
            n0 += int'(a0); n1 += int'(a1);
        end
        check("bp_accepts0", 64'(n0), 64'd4);
        check("bp_accepts1", 64'(n1), 64'd8);
        for (int i = 0; i < 6; i++)
            step(1'b1, rq(1'b0, 32'h110, $urandom), 1'b1, 1'b1, rq(1'b0, 32'h21C, $urandom), 1'b1, a0, a1);
        idle(6, 1'b1);

        // Same-edge read/write and dual write
        step(1'b1, rq(1'b1, 32'h300, 32'hDEAD_BEEF), 1'b1, 1'b1, rq(1'b0, 32'h300, $urandom), 1'b1, a0, a1);
        step(1'b1, rq(1'b0, 32'h300, $urandom), 1'b1, 1'b0, '0, 1'b1, a0, a1);
        step(1'b1, rq(1'b1, 32'h304, 32'hAAAA_0000), 1'b1, 1'b1, rq(1'b1, 32'h304, 32'h5555_FFFF), 1'b1, a0, a1);
        step(1'b1, rq(1'b0, 32'h304, $urandom), 1'b1, 1'b1, rq(1'b0, 32'h304, $urandom), 1'b1, a0, a1);
        idle(4, 1'b1);

        // Reset with three responses queued on port 0
        for (int i = 0; i < 3; i++)
            step(1'b1, rq(1'b0, 32'h104 + 32'(4 * i), $urandom), 1'b0, 1'b0, '0, 1'b1, a0, a1);
        idle(3, 1'b0);
        check("pre_rst_resp0_val", 64'(bus.memresp0_val), 64'h1);
        #2 reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("mid_rst_resp0_val", 64'(bus.memresp0_val), 64'h0);
        check("mid_rst_req0_rdy", 64'(bus.memreq0_rdy), 64'h0);
        check("mid_rst_req1_rdy", 64'(bus.memreq1_rdy), 64'h0);
        idle(2, 1'b1);
        @(negedge clk) reset = 1'b1;
        idle(3, 1'b1);
        step(1'b1, rq(1'b0, 32'h100, $urandom), 1'b1, 1'b0, '0, 1'b1, a0, a1);
        check("post_rst_acc0", 64'(a0), 64'h1);
        idle(4, 1'b1);
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rq(1'b0, 32'h300, $urandom), 1'b0, 1'b0, '0, 1'b1, a0, a1);
            n0 += int'(a0);
        end
        check("post_rst_credits", 64'(n0), 64'd4);
        idle(8, 1'b1);

        // Random traffic over a small window so collisions are common
        for (int i = 0; i < 8; i++)
            step(1'b1, rq(1'b1, 32'h400 + 32'(4 * i), $urandom), 1'b1,
                 1'b1, rq(1'b1, 32'h420 + 32'(4 * i), $urandom), 1'b1, a0, a1);
        for (int i = 0; i < 400; i++) begin
            mem_req_msg_t r0, r1;
            a  = {12'($urandom), 18'(32'h100 + ($urandom % 16)), 2'($urandom)};
            r0 = rq(($urandom % 3) == 0, a, $urandom);
            a  = {12'($urandom), 18'(32'h100 + ($urandom % 16)), 2'($urandom)};
            r1 = rq(($urandom % 3) == 0, a, $urandom);
            step(($urandom % 4) != 0, r0, ($urandom % 4) != 0,
                 ($urandom % 4) != 0, r1, ($urandom % 4) != 0, a0, a1);
        end

        k = 0;
        while ((q0.size() + q1.size()) > 0 && k < 200) begin
            idle(1, 1'b1);
            k++;
        end
        check("drain_empty", 64'(q0.size() + q1.size()), 64'h0);
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_dual_imem_responder.md
# riscv_dual_imem_responder

- Responder end of the two instruction-fetch memory ports used by the dual-fetch core.
- Accepts VC memory request messages on two independent ports and returns response messages after a fixed pipeline latency.
- Buffers responses so that a deasserted response-ready stalls only its own port.
- Sits between the core's instruction request/response interfaces and a shared word-array memory image that the simulator loads with `$readmemh`.

## Interface
- p_mem_sz, 1<<20: memory size in bytes; array depth is p_mem_sz/4 words.
- p_addr_sz, 32: request address width.
- p_data_sz, 32: data width. Only 32 is supported; the len field is 2 bits.
- p_latency, 2: cycles from request accept to response valid, 1..4.
- p_q_depth, 4: per-port credit limit (in-flight plus queued responses), p_q_depth ≥ p_latency+1.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memreq0_val / memreq1_val  input  1  request valid.
- memreq0_rdy / memreq1_rdy  output  1  request ready.
- memreq0_msg / memreq1_msg  input  67  request: {type[66], addr[65:34], len[33:32], data[31:0]}; type 0 = read, 1 = write.
- memresp0_val / memresp1_val  output  1  response valid.
- memresp0_rdy / memresp1_rdy  input  1  response ready.
- memresp0_msg / memresp1_msg  output  35  response: {type[34], len[33:32], data[31:0]}.

## Operation
- A request is accepted on a rising edge where val && rdy.
- Word index is addr[log2(p_mem_sz)-1:2]. Upper address bits and addr[1:0] are ignored.
- Read:
  - The array is read at the accept edge.
  - Response is {0, len, m[idx]}. A nonzero len still returns the full word.
- Write:
  - m[idx] <= data at the accept edge.
  - Response is {1, len, 32'h0}.
- If both ports write the same index on the same edge, port 1's data wins.
- If one port reads and the other writes the same index on the same edge, the read returns the old data.
- Per port:
  - A p_latency-deep valid/msg delay line feeds a response FIFO of depth p_q_depth.
  - A credit counter cnt (0..p_q_depth) increments on accept and decrements on response fire. Both on the same edge leave it unchanged.
  - rdy = reset deasserted && cnt < p_q_depth.
  - The FIFO therefore never overflows, and the delay line never stalls.
- Responses on a port are returned in the order their requests were accepted. The two ports are fully independent.
- Memory contents are not affected by reset.

## Timing
- Asserting reset clears asynchronously: cnt, delay-line valids, FIFO pointers, memresp*_val = 0, memreq*_rdy = 0.
- First accept is possible on the first rising edge after reset deasserts.
- Request accepted at edge t → resp val is high in the cycle after edge t+p_latency-1, i.e. p_latency cycles later.
- Resp val stays high and msg stays stable until resp val && rdy.
- Full throughput of 1 request per cycle per port is sustained while resp rdy = 1.
- FIFO bypass is not allowed: a delay-line output enters the FIFO and appears no earlier than the latency above.
- Wrap-around: FIFO pointers wrap modulo p_q_depth. The cnt arithmetic must never underflow or overflow.
- Reset asserted mid-operation drops all in-flight and queued responses. Writes already accepted remain in memory.

## Structure
- Message field widths and offsets for the 67-bit request and 35-bit response come from the shared VC memory message definitions (VC_MEM_REQ_MSG_SZ / VC_MEM_RESP_MSG_SZ and field macros). No local redefinition.
- One sub-module, riscv_ImemRespPort, holds the delay line, FIFO and credit counter. It is instantiated twice.
- The word array lives in the top module, named m, instance path mem.m, so the simulator's `$readmemh` loads it.

## Test plan
- Preload m[0x40] = 0x00500093.
  - Port 0 reads addr 0x100 at edge t, with resp rdy = 1.
  - Resp0 val is high p_latency = 2 cycles later with msg {0, 0, 0x00500093}.
- Port 0 reads 0x100..0x11C back-to-back while port 1 reads 0x200..0x21C.
  - 8 responses per port come back in order, 1 per cycle, and rdy never drops.
- Hold resp0 rdy = 0 while issuing reads on port 0.
  - Exactly 4 requests are accepted, then req0 rdy = 0.
  - Port 1 continues at full rate.
  - Raising resp0 rdy drains 4 responses in order and rdy returns on the same edge as the first drain.
- Same edge: port 0 writes 0xDEADBEEF to 0x300 while port 1 reads 0x300 (old value 0x11111111).
  - Port 1 returns 0x11111111.
  - A later read returns 0xDEADBEEF.
  - A simultaneous dual write to 0x304 keeps port 1's data.
- Assert reset with 3 responses queued on port 0.
  - Resp0 val falls immediately and req rdy = 0.
  - After release, cnt = 0, no stale response appears, and the next read returns the correct data.
